mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port memory between instruction fetch (IFU, read-only) and load/store (LSU).
//  Round-robin arbitration, one outstanding access, fixed memory read latency.
//  Drives addr_sel, the select of the 2:1 address/data mux in front of the memory.
//  Sits between the core control FSM and the unified instruction/data memory.
// PARAMETERS
//  DATA_WIDTH   32  width of wdata/rdata
//  ADDR_WIDTH   32  width of all addresses
//  MEM_LATENCY  2   cycles from mem_en to valid mem_rdata; legal 1..15
// PORTS
//  clk        in   1           single clock, rising edge
//  rst        in   1           reset, asynchronous, active-high
//  ifu_req    in   1           IFU read request; held with ifu_addr until ifu_ack
//  ifu_addr   in   ADDR_WIDTH  IFU address
//  ifu_ack    out  1           one-cycle pulse: IFU access complete, rdata valid
//  lsu_req    in   1           LSU request; held with lsu_we/addr/wdata until lsu_ack
//  lsu_we     in   1           1 = write, 0 = read
//  lsu_addr   in   ADDR_WIDTH  LSU address
//  lsu_wdata  in   DATA_WIDTH  LSU write data
//  lsu_ack    out  1           one-cycle pulse: LSU access complete
//  rdata      out  DATA_WIDTH  registered read data; updated on reads only
//  addr_sel   out  1           registered mux select: 0 = IFU, 1 = LSU
//  busy       out  1           1 when state != IDLE
//  mem_en     out  1           one-cycle memory strobe
//  mem_we     out  1           write enable, valid with mem_en
//  mem_addr   out  ADDR_WIDTH  latched address
//  mem_wdata  out  DATA_WIDTH  latched write data
//  mem_rdata  in   DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after mem_en
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, last_grant = LSU, latency counter 0.
//  Because last_grant resets to LSU, the IFU wins the first conflict.
//  Reset asserted mid-transaction aborts it immediately: no ack, no further mem_en.
//  FSM:
//   IDLE:  if any req, pick a winner (below), then go to ISSUE on the same edge.
//          On that edge latch owner->addr_sel, addr->mem_addr, wdata->mem_wdata, we->mem_we
//          (IFU: we = 0, wdata = 0), and set last_grant = owner.
//   ISSUE: mem_en = 1 for exactly this cycle. Load counter = MEM_LATENCY-1. Go to WAIT.
//   WAIT:  decrement the counter. When counter == 0, mem_rdata is valid:
//          on reads capture it into rdata, then go to RESP.
//   RESP:  assert the owner's ack for one cycle, then go to IDLE.
//  Arbitration:
//   - Single requester: granted.
//   - Both requesting: grant the one != last_grant.
//   - A request arriving while busy waits for IDLE.
//  Latency: req sampled in IDLE cycle t -> mem_en at t+1 -> ack at t+2+MEM_LATENCY.
//   A held req is re-sampled in the IDLE cycle after RESP, giving a minimum
//   period of MEM_LATENCY+3 cycles per access.
//  Writes use the same timing; rdata keeps its previous value.
//  Outside ISSUE, mem_we/mem_addr/mem_wdata hold their latched values; mem_en = 0.
//  addr_sel holds the last owner while IDLE.
//  Requester dropping req mid-access is a protocol violation. The block still completes
//  the access and acks; the ack is ignorable.
//  ifu_ack and lsu_ack are never high in the same cycle.
//  Counter width: $clog2(MEM_LATENCY+1). MEM_LATENCY = 1 gives zero WAIT decrements
//  (exactly one WAIT cycle).
// STRUCTURE
//  Package mem_arb_pkg:
//   - typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t
//   - localparams OWNER_IFU = 1'b0, OWNER_LSU = 1'b1
//  Sub-module rr_pick_2: combinational 2-way round-robin picker
//   - inputs: req[1:0], last
//   - outputs: gnt_valid, gnt_id
//  Everything else (FSM, latency counter, latches) stays in this module.
// TESTING (MEM_LATENCY = 2 unless noted; memory model returns data MEM_LATENCY cycles after mem_en)
//  1. ifu_req at cycle 0, ifu_addr = 0x0000_0004, memory holds 0xDEADBEEF
//     -> mem_en = 1, mem_we = 0, mem_addr = 0x4 at cycle 1
//     -> ifu_ack at cycle 4, rdata = 0xDEADBEEF, lsu_ack never high.
//  2. Both req high from the cycle after reset release, held
//     -> grants alternate IFU, LSU, IFU, LSU; addr_sel = 0, 1, 0, 1; acks 5 cycles apart.
//  3. lsu_req, we = 1, addr = 0x100, wdata = 0x1234_5678
//     -> one mem_en cycle with mem_we = 1, mem_wdata = 0x1234_5678
//     -> lsu_ack at cycle 4, rdata unchanged.
//  4. rst pulsed during WAIT
//     -> all outputs 0 asynchronously, no ack for the aborted access;
//     -> after release, simultaneous requests grant IFU first.
//  5. MEM_LATENCY = 1, continuous ifu_req
//     -> mem_en every 4 cycles, ack at t+3, rdata captured from mem_rdata at t+2.
//  6. lsu_req arrives in IFU's ISSUE cycle
//     -> LSU waits; served immediately after the IFU RESP -> IDLE, no mem_en overlap.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

endpackage

// File: rtl/rr_pick_2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one
// that was not granted last. req[0] is the IFU, req[1] the LSU.
module rr_pick_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = req[1];
    if (&req) gnt_id = ~last;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port memory between instruction fetch and load/store with
// round-robin arbitration, one outstanding access and fixed read latency.
module mem_port_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req,
  input  logic [ADDR_WIDTH-1:0] ifu_addr,
  output logic                  ifu_ack,
  input  logic                  lsu_req,
  input  logic                  lsu_we,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  output logic                  lsu_ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  addr_sel,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  import mem_arb_pkg::*;

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  arb_state_t            state_q, state_d;
  logic                  last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  addr_sel_q, addr_sel_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ifu_ack_q, ifu_ack_d;
  logic                  lsu_ack_q, lsu_ack_d;
  logic                  busy_q, busy_d;

  logic gnt_valid;
  logic gnt_id;

  rr_pick_2 u_pick (
    .req       ({lsu_req, ifu_req}),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    addr_sel_d  = addr_sel_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    ifu_ack_d   = 1'b0;
    lsu_ack_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d    = ISSUE;
          last_d     = gnt_id;
          addr_sel_d = gnt_id;
          mem_en_d   = 1'b1;
          if (gnt_id == OWNER_LSU) begin
            mem_we_d    = lsu_we;
            mem_addr_d  = lsu_addr;
            mem_wdata_d = lsu_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = ifu_addr;
            mem_wdata_d = '0;
          end
        end
      end
      ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        // Ack is raised on the capture edge so it lands in the RESP cycle.
        if (cnt_q == '0) begin
          if (!mem_we_q) rdata_d = mem_rdata;
          state_d = RESP;
          if (addr_sel_q == OWNER_LSU) lsu_ack_d = 1'b1;
          else                         ifu_ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= OWNER_LSU;
      cnt_q       <= '0;
      addr_sel_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      ifu_ack_q   <= 1'b0;
      lsu_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      addr_sel_q  <= addr_sel_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      ifu_ack_q   <= ifu_ack_d;
      lsu_ack_q   <= lsu_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign ifu_ack   = ifu_ack_q;
  assign lsu_ack   = lsu_ack_q;
  assign rdata     = rdata_q;
  assign addr_sel  = addr_sel_q;
  assign busy      = busy_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
